// File: rtl/dmac_pkg.sv
// dmac_pkg: shared DMAC widths and descriptor geometry.
package dmac_pkg;
    localparam int DMAC_ADDR_W     = 32;
    localparam int DMAC_SIZE_W     = 32;
    localparam int DMAC_DESC_DEPTH = 16;
    localparam int DESC_W          = 2 * DMAC_ADDR_W + DMAC_SIZE_W;
endpackage

// File: rtl/dmac_desc_fifo_if.sv
// dmac_desc_fifo_if: push/pop/status bundle between the register slave and the master engine.
interface dmac_desc_fifo_if
    import dmac_pkg::*;
#(
    parameter int ADDR_W = DMAC_ADDR_W,
    parameter int SIZE_W = DMAC_SIZE_W,
    parameter int DEPTH  = DMAC_DESC_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              flush;
    logic              wr_en;
    logic [ADDR_W-1:0] src_addr_in;
    logic [ADDR_W-1:0] dest_addr_in;
    logic [SIZE_W-1:0] data_size_in;
    logic              rd_en;
    logic [ADDR_W-1:0] src_addr_out;
    logic [ADDR_W-1:0] dest_addr_out;
    logic [SIZE_W-1:0] data_size_out;
    logic              wr_ack;
    logic              wr_err;
    logic              rd_ack;
    logic              rd_err;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CW-1:0]     data_count;

    modport slave (
        input  flush, wr_en, src_addr_in, dest_addr_in, data_size_in, rd_en,
        output src_addr_out, dest_addr_out, data_size_out, wr_ack, wr_err,
               rd_ack, rd_err, full, empty, almost_full, data_count
    );
    modport master (
        output flush, wr_en, src_addr_in, dest_addr_in, data_size_in, rd_en,
        input  src_addr_out, dest_addr_out, data_size_out, wr_ack, wr_err,
               rd_ack, rd_err, full, empty, almost_full, data_count
    );
endinterface

// File: rtl/dmac_desc_ram.sv
// dmac_desc_ram: descriptor storage, synchronous write, asynchronous read.
module dmac_desc_ram
    import dmac_pkg::*;
#(
    parameter int DW    = DESC_W,
    parameter int DEPTH = DMAC_DESC_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [PW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dmac_desc_fifo.sv
// dmac_desc_fifo: descriptor queue with ack/err pulses, status flags and flush.
// All three fields share one entry so they can never drift apart.
module dmac_desc_fifo
    import dmac_pkg::*;
#(
    parameter int ADDR_W    = DMAC_ADDR_W,
    parameter int SIZE_W    = DMAC_SIZE_W,
    parameter int DEPTH     = DMAC_DESC_DEPTH,
    parameter int AFULL_LVL = 14
) (
    input logic              clk,
    input logic              reset_n,
    dmac_desc_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 2 * ADDR_W + SIZE_W;

    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_src, r_dest;
    logic [SIZE_W-1:0] r_size;
    logic              r_wr_ack, r_wr_err, r_rd_ack, r_rd_err;
    logic [DW-1:0]     w_rd_data;
    logic              w_empty, w_full, w_rd, w_wr;

    assign w_empty = r_count == '0;
    assign w_full  = r_count == CW'(DEPTH);
    assign w_rd    = !bus.flush && bus.rd_en && !w_empty;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign w_wr    = !bus.flush && bus.wr_en && (!w_full || w_rd);

    dmac_desc_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata ({bus.src_addr_in, bus.dest_addr_in, bus.data_size_in}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_src    <= '0;
            r_dest   <= '0;
            r_size   <= '0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_ack <= w_wr;
            r_wr_err <= !bus.flush && bus.wr_en && !w_wr;
            r_rd_ack <= w_rd;
            r_rd_err <= !bus.flush && bus.rd_en && w_empty;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_rd) {r_src, r_dest, r_size} <= w_rd_data;
                if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count <= r_count + CW'(w_wr) - CW'(w_rd);
            end
        end
    end

    assign bus.src_addr_out  = r_src;
    assign bus.dest_addr_out = r_dest;
    assign bus.data_size_out = r_size;
    assign bus.wr_ack        = r_wr_ack;
    assign bus.wr_err        = r_wr_err;
    assign bus.rd_ack        = r_rd_ack;
    assign bus.rd_err        = r_rd_err;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.almost_full   = r_count >= CW'(AFULL_LVL);
    assign bus.data_count    = r_count;
endmodule

// File: tb/tb_dmac_desc_fifo.sv
// tb_dmac_desc_fifo: directed and random steps checked against a queue model of the descriptor FIFO.
module tb_dmac_desc_fifo;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] z;
    } desc_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmac_desc_fifo_if #(.ADDR_W(32), .SIZE_W(32), .DEPTH(DEPTH)) bus ();

    dmac_desc_fifo #(.ADDR_W(32), .SIZE_W(32), .DEPTH(DEPTH), .AFULL_LVL(AFL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    desc_t q[$];
    desc_t e_out;
    logic  e_wack, e_werr, e_rack, e_rerr;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("wr_ack", 64'(bus.wr_ack), 64'(e_wack));
        chk("wr_err", 64'(bus.wr_err), 64'(e_werr));
        chk("rd_ack", 64'(bus.rd_ack), 64'(e_rack));
        chk("rd_err", 64'(bus.rd_err), 64'(e_rerr));
        chk("src_out", 64'(bus.src_addr_out), 64'(e_out.s));
        chk("dest_out", 64'(bus.dest_addr_out), 64'(e_out.d));
        chk("size_out", 64'(bus.data_size_out), 64'(e_out.z));
        chk("count", 64'(bus.data_count), 64'(q.size()));
        chk("full", 64'(bus.full), 64'(q.size() == DEPTH));
        chk("empty", 64'(bus.empty), 64'(q.size() == 0));
        chk("afull", 64'(bus.almost_full), 64'(q.size() >= AFL));
    endtask

    task automatic model_reset();
        q.delete();
        e_out = '0;
        {e_wack, e_werr, e_rack, e_rerr} = '0;
    endtask

    // One clock: drive, take the edge, advance the model, compare.
    task automatic step(input bit wr, input bit rd, input bit fl, input desc_t din);
        bit rok, wok;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.flush = fl;
        {bus.src_addr_in, bus.dest_addr_in, bus.data_size_in} = din;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            {e_wack, e_werr, e_rack, e_rerr} = '0;
        end else begin
            rok = rd && q.size() > 0;
            wok = wr && (q.size() < DEPTH || rok);
            if (rok) e_out = q.pop_front();
            if (wok) q.push_back(din);
            e_rack = rok;
            e_rerr = rd && !rok;
            e_wack = wok;
            e_werr = wr && !wok;
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
        check_all();
    endtask

    function automatic desc_t rnd();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic desc_t with_src(input int i);
        desc_t t = rnd();
        t.s = i;
        return t;
    endfunction

    initial begin
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        {bus.src_addr_in, bus.dest_addr_in, bus.data_size_in} = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, rnd());

        // Single push then pop
        step(1, 0, 0, {32'h1000, 32'h2000, 32'h40});
        step(0, 1, 0, rnd());
        chk("pop_src", 64'(bus.src_addr_out), 64'h1000);
        step(0, 0, 0, rnd());

        // Two full fill/drain rounds exercise pointer wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) step(1, 0, 0, with_src(i));
            step(1, 0, 0, with_src(99));
            for (int i = 0; i < DEPTH; i++) begin
                step(0, 1, 0, rnd());
                chk("order_src", 64'(bus.src_addr_out), 64'(i));
            end
        end

        // Full: simultaneous pop and push
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, with_src(i));
        step(1, 1, 0, with_src(77));
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, rnd());
        chk("new_last", 64'(bus.src_addr_out), 64'd77);

        // Empty: simultaneous pop and push, no bypass
        step(1, 1, 0, rnd());
        step(0, 1, 0, rnd());

        // Flush beats concurrent push and pop
        for (int i = 0; i < 5; i++) step(1, 0, 0, rnd());
        step(1, 1, 1, rnd());
        step(0, 1, 0, rnd());

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0, rnd());

        // Async reset mid-burst
        for (int i = 0; i < 6; i++) step(1, 0, 0, rnd());
        bus.wr_en = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        bus.wr_en = 1'b0;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1, 0, rnd());
        step(1, 0, 0, rnd());
        step(0, 1, 0, rnd());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmac_desc_fifo.md
Name: dmac_desc_fifo

Overview:
Parametrised descriptor queue between the DMAC slave register interface and the DMAC master engine. Each entry is one descriptor of {src_addr, dest_addr, data_size}, held in a single shared storage array with one pointer pair, so the three fields cannot lose alignment. Adds full/empty/almost-full status, an occupancy count, a write acknowledge and a synchronous flush.

Parameters:
ADDR_W, 32, width of src_addr and dest_addr fields
SIZE_W, 32, width of data_size field
DEPTH, 16, number of descriptor entries; power of two, >= 2
AFULL_LVL, 14, almost_full asserts when count >= AFULL_LVL; range 1..DEPTH

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries
wr_en  in  1  push request
src_addr_in  in  ADDR_W  descriptor source address
dest_addr_in  in  ADDR_W  descriptor destination address
data_size_in  in  SIZE_W  descriptor transfer size
rd_en  in  1  pop request
src_addr_out  out  ADDR_W  popped source address, registered
dest_addr_out  out  ADDR_W  popped destination address, registered
data_size_out  out  SIZE_W  popped size, registered
wr_ack  out  1  push accepted, one cycle after wr_en
wr_err  out  1  push rejected (full), one cycle after wr_en
rd_ack  out  1  pop accepted, outputs valid, one cycle after rd_en
rd_err  out  1  pop rejected (empty), one cycle after rd_en
full  out  1  count == DEPTH, combinational from count
empty  out  1  count == 0, combinational from count
almost_full  out  1  count >= AFULL_LVL
data_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset_n low, async): wr_ptr = rd_ptr = 0, count = 0; all data outputs 0; wr_ack, wr_err, rd_ack, rd_err = 0; empty = 1, full = 0, almost_full = 0. Storage contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked separately, width $clog2(DEPTH)+1.
- Per rising edge, in priority order:
  - flush = 1: pointers and count go to 0; all four ack/err flags go to 0 next cycle; data outputs hold; wr_en and rd_en are ignored (no ack, no err).
  - Read, judged on count before the edge:
    - rd_en and count > 0: entry[rd_ptr] is loaded into the three output registers; rd_ptr increments; rd_ack = 1 next cycle.
    - rd_en and count == 0: rd_err = 1 next cycle; outputs hold.
    - No bypass: a read in the same cycle as the first write to an empty FIFO still errors.
  - Write:
    - wr_en and (count < DEPTH, or count == DEPTH with a read accepted this cycle): inputs are stored at entry[wr_ptr]; wr_ptr increments; wr_ack = 1 next cycle.
    - Otherwise wr_en with count == DEPTH: wr_err = 1 next cycle; storage unchanged.
  - count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flag timing: ack/err flags are single-cycle pulses, registered, cleared whenever the corresponding enable is low. Back-to-back enables give back-to-back pulses.
- Read latency: 1 cycle. Output registers hold their value between pops.
- Status outputs reflect the registered count in the same cycle count changes.
- Reset mid-operation: immediate return to reset values; any in-flight ack or err is dropped.

Decomposition:
- Shared package dmac_pkg: DMAC_ADDR_W = 32, DMAC_SIZE_W = 32, DMAC_DESC_DEPTH = 16, and the descriptor width DESC_W = 2*ADDR_W + SIZE_W.
- One sub-module, dmac_desc_ram: DEPTH x DESC_W register array with a synchronous write port and an asynchronous read port at rd_ptr. Pointer, count and flag control lives in the top.

Test Plan:
- Reset then idle -> empty=1, full=0, data_count=0, all ack/err=0, outputs 0.
- Push (0x1000, 0x2000, 0x40), then one cycle later pop -> wr_ack pulse; on the cycle after rd_en, rd_ack=1 and outputs read 0x1000 / 0x2000 / 0x40; empty=1 afterwards.
- 16 pushes with src = i -> almost_full rises after the 14th, full=1 and data_count=16 after the 16th; a 17th push -> wr_err=1 and contents unchanged; 16 pops return src 0..15 in order, through pointer wrap on a second fill.
- When full, simultaneous rd_en and wr_en -> rd_ack=1 and wr_ack=1, data_count stays 16, the new entry appears 16th in pop order. When empty, simultaneous rd_en and wr_en -> rd_err=1, wr_ack=1, data_count=1.
- Load 5 entries, assert flush together with rd_en and wr_en -> no ack or err; data_count=0, empty=1; the next pop gives rd_err=1.
- Assert reset_n low mid-burst, between clock edges -> all outputs at reset values immediately; after release, the first pop gives rd_err=1.
